// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : ID-side hazard unit covering load-use, branch squash, memory
//            stalls and halt, with a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       IFID_Rs,
  input  logic [2:0]       IFID_Rt,
  input  logic             ReadingRs_IFID,
  input  logic             ReadingRt_IFID,
  input  logic [2:0]       IDEX_Rd,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic             branch_taken_EX,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             halt_MEM,
  output logic             PC_write_en,
  output logic             IFID_write_en,
  output logic             IDEX_bubble,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             pipe_freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    LU_DONE  = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_stallCycles;
  logic             w_loadUse;
  logic             w_pcWrite;
  logic             w_ifidWrite;
  logic             w_bubble;
  logic             w_ifidFlush;
  logic             w_idexFlush;
  logic             w_freeze;

  assign w_loadUse = IDEX_MemRead & IDEX_RegWrite &
                     ((ReadingRs_IFID & (IFID_Rs == IDEX_Rd)) |
                      (ReadingRt_IFID & (IFID_Rt == IDEX_Rd)));

  always_comb begin
    w_pcWrite   = 1'b1;
    w_ifidWrite = 1'b1;
    w_bubble    = 1'b0;
    w_ifidFlush = 1'b0;
    w_idexFlush = 1'b0;
    w_freeze    = 1'b0;
    w_nextState = RUN;
    if (r_state == HALTED) begin
      w_pcWrite   = 1'b0;
      w_ifidWrite = 1'b0;
      w_freeze    = 1'b1;
      w_nextState = HALTED;
    end else if (dmem_stall) begin
      w_pcWrite   = 1'b0;
      w_ifidWrite = 1'b0;
      w_freeze    = 1'b1;
      w_nextState = MEM_WAIT;
    end else begin
      // A squashing branch removes the dependent instruction, so it beats load-use.
      if (branch_taken_EX) begin
        w_ifidFlush = 1'b1;
        w_idexFlush = 1'b1;
      end else if (w_loadUse && (r_state != LU_DONE)) begin
        w_pcWrite   = 1'b0;
        w_ifidWrite = 1'b0;
        w_bubble    = 1'b1;
        w_nextState = LU_DONE;
      end else if (imem_stall) begin
        w_pcWrite   = 1'b0;
        w_ifidWrite = 1'b0;
        w_bubble    = 1'b1;
      end
      if (halt_MEM) begin
        w_nextState = HALTED;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_stallCycles <= '0;
    end else begin
      r_state <= w_nextState;
      if (!w_pcWrite && (r_state != HALTED) && (r_stallCycles != c_CNT_MAX)) begin
        r_stallCycles <= r_stallCycles + c_CNT_ONE;
      end
    end
  end

  // Reset forces idle outputs immediately, even while stall inputs are still high.
  assign PC_write_en   = rst | w_pcWrite;
  assign IFID_write_en = rst | w_ifidWrite;
  assign IDEX_bubble   = ~rst & w_bubble;
  assign IFID_flush    = ~rst & w_ifidFlush;
  assign IDEX_flush    = ~rst & w_idexFlush;
  assign pipe_freeze   = ~rst & w_freeze;
  assign halted        = ~rst & (r_state == HALTED);
  assign stall_cycles  = r_stallCycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Vector table, corner sequences and random run against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Output vector order: {PC_write_en, IFID_write_en, IDEX_bubble, IFID_flush, IDEX_flush, pipe_freeze, halted}
  localparam logic [6:0] c_NORM = 7'b1100000;
  localparam logic [6:0] c_STL  = 7'b0010000;
  localparam logic [6:0] c_BR   = 7'b1101100;
  localparam logic [6:0] c_FRZ  = 7'b0000010;
  localparam logic [6:0] c_HLT  = 7'b0000011;

  typedef struct {
    logic [2:0] rs, rt, rd;
    logic       rdRs, rdRt, memRead, regWrite, br, imem, dmem, halt;
    logic [6:0] expOut;
    int         expCnt;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       IFID_Rs = '0, IFID_Rt = '0, IDEX_Rd = '0;
  logic             ReadingRs_IFID = 1'b0, ReadingRt_IFID = 1'b0;
  logic             IDEX_MemRead = 1'b0, IDEX_RegWrite = 1'b0;
  logic             branch_taken_EX = 1'b0, imem_stall = 1'b0, dmem_stall = 1'b0, halt_MEM = 1'b0;
  logic             PC_write_en, IFID_write_en, IDEX_bubble, IFID_flush, IDEX_flush, pipe_freeze, halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [6:0]       w_outs;

  int nTests = 0;
  int nFail  = 0;

  vec_t tbl[14];

  // Model state: sticky halt and "a load-use bubble was issued last cycle".
  bit mHalted;
  bit mMask;
  int mCnt;

  hazard_stall_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .ReadingRs_IFID(ReadingRs_IFID), .ReadingRt_IFID(ReadingRt_IFID),
    .IDEX_Rd(IDEX_Rd), .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite),
    .branch_taken_EX(branch_taken_EX), .imem_stall(imem_stall),
    .dmem_stall(dmem_stall), .halt_MEM(halt_MEM),
    .PC_write_en(PC_write_en), .IFID_write_en(IFID_write_en),
    .IDEX_bubble(IDEX_bubble), .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .pipe_freeze(pipe_freeze), .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign w_outs = {PC_write_en, IFID_write_en, IDEX_bubble, IFID_flush, IDEX_flush, pipe_freeze, halted};

  function automatic vec_t mk(int rs, int rt, int rd, bit rdRs, bit rdRt, bit mr, bit rw,
                              bit br, bit im, bit dm, bit ht, logic [6:0] e, int c);
    vec_t v;
    v.rs = 3'(rs); v.rt = 3'(rt); v.rd = 3'(rd);
    v.rdRs = rdRs; v.rdRt = rdRt; v.memRead = mr; v.regWrite = rw;
    v.br = br; v.imem = im; v.dmem = dm; v.halt = ht;
    v.expOut = e; v.expCnt = c;
    return v;
  endfunction

  task automatic setIn(input vec_t v);
    IFID_Rs = v.rs; IFID_Rt = v.rt; IDEX_Rd = v.rd;
    ReadingRs_IFID = v.rdRs; ReadingRt_IFID = v.rdRt;
    IDEX_MemRead = v.memRead; IDEX_RegWrite = v.regWrite;
    branch_taken_EX = v.br; imem_stall = v.imem; dmem_stall = v.dmem; halt_MEM = v.halt;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    setIn(mk(0,0,0,0,0,0,0,0,0,0,0,c_NORM,0));
    #1 chk("reset_outs", int'(w_outs), int'(c_NORM));
    chk("reset_cnt", int'(stall_cycles), 0);
    #1 rst = 1'b0;
  endtask

  // One cycle of inputs: drive at negedge, check just after, edge follows.
  task automatic stepChk(input string name, input vec_t v);
    @(negedge clk);
    setIn(v);
    #1 chk({name, "_outs"}, int'(w_outs), int'(v.expOut));
    chk({name, "_cnt"}, int'(stall_cycles), v.expCnt);
  endtask

  function automatic logic [6:0] modelOut(input vec_t v);
    bit lu;
    lu = v.memRead && v.regWrite &&
         ((v.rdRs && v.rs == v.rd) || (v.rdRt && v.rt == v.rd));
    if (mHalted)             return c_HLT;
    if (v.dmem)              return c_FRZ;
    if (v.br)                return c_BR;
    if (lu && !mMask)        return c_STL;
    if (v.imem)              return c_STL;
    return c_NORM;
  endfunction

  initial begin
    vec_t v;
    logic [6:0] e;

    tbl[0]  = mk(0,0,0, 0,0, 0,0, 0,0,0,0, c_NORM, 0);
    tbl[1]  = mk(3,0,3, 1,0, 1,1, 0,0,0,0, c_STL,  0);
    tbl[2]  = mk(3,0,3, 1,0, 1,1, 0,0,0,0, c_NORM, 1);
    tbl[3]  = mk(3,0,3, 0,0, 1,1, 0,0,0,0, c_NORM, 1);
    tbl[4]  = mk(3,0,3, 1,0, 0,1, 0,0,0,0, c_NORM, 1);
    tbl[5]  = mk(0,5,5, 0,1, 1,1, 0,0,0,0, c_STL,  1);
    tbl[6]  = mk(0,0,0, 0,0, 0,0, 0,0,0,0, c_NORM, 2);
    tbl[7]  = mk(3,0,3, 1,0, 1,1, 1,0,0,0, c_BR,   2);
    tbl[8]  = mk(0,0,0, 0,0, 0,0, 1,0,1,0, c_FRZ,  2);
    tbl[9]  = mk(0,0,0, 0,0, 0,0, 0,1,0,0, c_STL,  3);
    tbl[10] = mk(3,0,3, 1,0, 1,0, 0,0,0,0, c_NORM, 4);
    tbl[11] = mk(0,0,0, 0,0, 0,0, 0,0,0,1, c_NORM, 4);
    tbl[12] = mk(3,0,3, 1,0, 1,1, 1,1,0,0, c_HLT,  4);
    tbl[13] = mk(0,0,0, 0,0, 0,0, 0,0,1,0, c_HLT,  4);

    repeat (2) @(posedge clk);
    doReset();
    for (int i = 0; i < 14; i++) stepChk($sformatf("tbl%0d", i), tbl[i]);
    stepChk("halt_sticky", mk(0,0,0, 0,0, 0,0, 0,0,0,1, c_HLT, 4));
    doReset();
    stepChk("after_halt_rst", mk(0,0,0, 0,0, 0,0, 0,0,0,0, c_NORM, 0));

    // dmem stall held across a pending load-use, then exactly one bubble.
    doReset();
    for (int i = 0; i < 4; i++)
      stepChk($sformatf("dmem_lu%0d", i), mk(3,0,3, 1,0, 1,1, 0,0,1,0, c_FRZ, i));
    stepChk("dmem_lu_bubble", mk(3,0,3, 1,0, 1,1, 0,0,0,0, c_STL, 4));
    stepChk("dmem_lu_after", mk(0,0,0, 0,0, 0,0, 0,0,0,0, c_NORM, 5));

    // Counter saturation, then asynchronous reset away from any clock edge.
    doReset();
    v = mk(0,0,0, 0,0, 0,0, 0,1,0,0, c_STL, 0);
    @(negedge clk);
    setIn(v);
    repeat ((1 << CNT_W) + 3) @(posedge clk);
    #2 chk("sat_cnt", int'(stall_cycles), CNT_MAX);
    chk("sat_outs", int'(w_outs), int'(c_STL));
    rst = 1'b1;
    #1 chk("async_rst_outs", int'(w_outs), int'(c_NORM));
    chk("async_rst_cnt", int'(stall_cycles), 0);
    #1 rst = 1'b0;

    // Randomised run against the flag-based model.
    doReset();
    mHalted = 1'b0; mMask = 1'b0; mCnt = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      v = mk($urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3),
             $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
             ($urandom_range(0,3) != 0), ($urandom_range(0,7) == 0),
             ($urandom_range(0,5) == 0), ($urandom_range(0,5) == 0),
             ($urandom_range(0,149) == 0), c_NORM, 0);
      setIn(v);
      if ($urandom_range(0,99) == 0) begin
        rst = 1'b1;
        #1 chk("rnd_rst_outs", int'(w_outs), int'(c_NORM));
        rst = 1'b0;
        mHalted = 1'b0; mMask = 1'b0; mCnt = 0;
      end
      e = modelOut(v);
      #1 chk("rnd_outs", int'(w_outs), int'(e));
      chk("rnd_cnt", int'(stall_cycles), mCnt);
      if (!e[6] && !mHalted && mCnt < CNT_MAX) mCnt++;
      mMask = !mHalted && !v.dmem && !v.br && (e == c_STL) && !mMask &&
              v.memRead && v.regWrite &&
              ((v.rdRs && v.rs == v.rd) || (v.rdRt && v.rt == v.rd));
      if (!mHalted && !v.dmem && v.halt) mHalted = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
